// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared definitions for the keypad scan controller: frame result codes,
// FSM states and the row/column to hex key map of the 4x4 keypad.
package keypad_pkg;

  // Frame result kinds produced after each complete four-column scan
  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_ONE   = 2'd1;
  localparam logic [1:0] RES_MULTI = 2'd2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  // One frame result; code is only meaningful for RES_ONE and is forced
  // to zero otherwise so that whole-struct compares behave.
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] code;
  } frame_res_t;

  // Row/column intersection to hex key code
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pins plus the decoded key outputs towards the display logic.
// master = scan controller, slave = keypad/consumer side.
interface keypad_scan_ctrl_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl_sync.sv
// Two-flop synchroniser for asynchronous inputs. The reset value is
// chosen by the instantiator so the idle level of the input is restored.
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Pmod 4x4 keypad scanner: strobes one column low at a time, samples the
// synchronised active-low rows at the end of each column dwell, classifies
// every complete frame, debounces whole frames and emits one code/valid
// pulse per accepted press (no auto-repeat, no rollover).
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 100_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CNT_W          = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  keypad_scan_ctrl_if.master        kp
);

  localparam int             DB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_SCANS);

  logic [3:0]       w_row_s;
  logic [CNT_W-1:0] r_dwell;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_col_n;
  logic             r_eval;
  logic             w_dwell_last;
  logic [15:0]      w_frame;     // bit col*4+row, low = intersection closed
  frame_res_t       w_res;
  frame_res_t       r_cand;
  logic [DB_W-1:0]  r_cnt;
  logic [DB_W-1:0]  w_cnt_next;
  state_t           r_state;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  // Rows idle high, so the synchroniser resets to "nothing pressed"
  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .i_d (kp.row_n),
    .o_q (w_row_s)
  );

  assign w_dwell_last = (r_dwell == CNT_W'(SCAN_CYCLES - 1));

  // Dwell counter and column ring; flags frame evaluation after the C4 sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell   <= '0;
      r_col_idx <= 2'd0;
      r_col_n   <= 4'b1110;
      r_eval    <= 1'b0;
    end else begin
      r_eval <= w_dwell_last && (r_col_idx == 2'd3);
      if (w_dwell_last) begin
        r_dwell   <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        r_col_n   <= {r_col_n[2:0], r_col_n[3]};
      end else begin
        r_dwell <= r_dwell + CNT_W'(1);
      end
    end
  end

  // One frame-buffer slot per column, loaded on that column's last dwell cycle
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic [3:0] r_col_rows;

      // Capture the row snapshot for column gi
      always_ff @(posedge clk) begin
        if (rst) begin
          r_col_rows <= 4'hF;
        end else if (w_dwell_last && (r_col_idx == 2'(gi))) begin
          r_col_rows <= w_row_s;
        end
      end

      assign w_frame[gi*4 +: 4] = r_col_rows;
    end
  endgenerate

  // Classify the frame: no, exactly one, or several closed intersections
  always_comb begin
    logic [1:0] hits;
    logic [3:0] code;
    hits = 2'd0;
    code = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!w_frame[c*4 + r]) begin
          if (hits != 2'd2) begin
            hits = hits + 2'd1;
          end
          code = key_map(2'(r), 2'(c));
        end
      end
    end
    w_res.kind = RES_MULTI;
    w_res.code = 4'h0;
    if (hits == 2'd0) begin
      w_res.kind = RES_NONE;
    end else if (hits == 2'd1) begin
      w_res.kind = RES_ONE;
      w_res.code = code;
    end
  end

  // Next debounce count: saturating on a repeated result, restart at 1 otherwise
  always_comb begin
    w_cnt_next = DB_W'(1);
    if (w_res == r_cand) begin
      w_cnt_next = (r_cnt == DB_MAX) ? r_cnt : r_cnt + DB_W'(1);
    end
  end

  // Debounce state update, once per evaluated frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand <= '{kind: RES_NONE, code: 4'h0};
      r_cnt  <= '0;
    end else if (r_eval) begin
      r_cand <= w_res;
      r_cnt  <= w_cnt_next;
    end
  end

  // Press/release FSM acting on the debounce result of the frame being evaluated
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (r_eval) begin
        case (r_state)
          ST_IDLE: begin
            if ((w_res.kind == RES_ONE) && (w_cnt_next == DB_MAX)) begin
              r_state     <= ST_PRESSED;
              r_key_code  <= w_res.code;
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if ((w_res.kind == RES_NONE) && (w_cnt_next == DB_MAX)) begin
              r_state    <= ST_IDLE;
              r_key_held <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign kp.col_n     = r_col_n;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;

endmodule
